// File: rtl/f_register_file_scb.sv
// FP register file with per-register busy scoreboard, write-through read bypass,
// and the fflags/frm/fcsr control state with rounding-mode resolution.
module f_register_file_scb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_READ   = 3,
    parameter int NUM_REGS   = 32
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_READ*5-1:0]          rs_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rs_data,
    output logic [NUM_READ-1:0]            rs_busy,
    input  logic                           wen,
    input  logic [4:0]                     rd,
    input  logic [DATA_WIDTH-1:0]          w_data,
    input  logic                           w_single,
    input  logic                           exc_valid,
    input  logic [4:0]                     exc_flags,
    input  logic                           iss_valid,
    input  logic [4:0]                     iss_rd,
    input  logic                           csr_wen,
    input  logic [1:0]                     csr_sel,
    input  logic [7:0]                     csr_wdata,
    input  logic [2:0]                     instr_rm,
    output logic [4:0]                     fflags,
    output logic [2:0]                     frm,
    output logic [7:0]                     fcsr,
    output logic [2:0]                     rm_out,
    output logic                           rm_illegal
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [DATA_WIDTH-1:0] wr_val;
    logic [4:0]            fflags_nxt;
    logic [2:0]            frm_nxt;

    // Single-precision results in a 64-bit file are NaN-boxed; the loop is empty at 32 bits.
    always_comb begin
        wr_val = w_data;
        for (int b = 32; b < DATA_WIDTH; b++) begin
            if (w_single) wr_val[b] = 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_read
        logic [4:0] addr;
        logic       hit;
        assign addr = rs_addr[5*i +: 5];
        assign hit  = wen && (rd == addr);
        assign rs_data[DATA_WIDTH*i +: DATA_WIDTH] = hit ? wr_val : regs[addr];
        // A same-cycle writeback releases the register; a same-cycle issue is not visible yet.
        assign rs_busy[i] = busy[addr] && !hit;
    end

    always_comb begin
        fflags_nxt = fflags;
        frm_nxt    = frm;
        if (csr_wen) begin
            case (csr_sel)
                2'b01: fflags_nxt = csr_wdata[4:0];
                2'b10: frm_nxt    = csr_wdata[2:0];
                2'b11: begin
                    frm_nxt    = csr_wdata[7:5];
                    fflags_nxt = csr_wdata[4:0];
                end
                default: ;
            endcase
        end
        // Exception flags accrue on top of whatever the CSR write left behind.
        if (exc_valid) fflags_nxt = fflags_nxt | exc_flags;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
            busy   <= '0;
            fflags <= '0;
            frm    <= '0;
        end else begin
            if (wen) begin
                regs[rd] <= wr_val;
                busy[rd] <= 1'b0;
            end
            // Later assignment wins, so issue beats a writeback to the same register.
            if (iss_valid) busy[iss_rd] <= 1'b1;
            fflags <= fflags_nxt;
            frm    <= frm_nxt;
        end
    end

    assign fcsr       = {frm, fflags};
    assign rm_out     = (instr_rm == 3'b111) ? frm : instr_rm;
    assign rm_illegal = (rm_out == 3'b101) || (rm_out == 3'b110) || (rm_out == 3'b111);

endmodule

// File: tb/tb_f_register_file_scb.sv
// Bench for f_register_file_scb at DATA_WIDTH=64: directed scenarios with literal
// expectations, then random traffic compared each cycle against an array-based model.
module tb_f_register_file_scb;

    localparam int DW = 64;
    localparam int NR = 3;

    logic           CLK = 1'b0;
    logic           RST;
    logic [NR*5-1:0]  rs_addr;
    logic [NR*DW-1:0] rs_data;
    logic [NR-1:0]  rs_busy;
    logic           wen;
    logic [4:0]     rd;
    logic [DW-1:0]  w_data;
    logic           w_single;
    logic           exc_valid;
    logic [4:0]     exc_flags;
    logic           iss_valid;
    logic [4:0]     iss_rd;
    logic           csr_wen;
    logic [1:0]     csr_sel;
    logic [7:0]     csr_wdata;
    logic [2:0]     instr_rm;
    logic [4:0]     fflags;
    logic [2:0]     frm;
    logic [7:0]     fcsr;
    logic [2:0]     rm_out;
    logic           rm_illegal;

    f_register_file_scb #(.DATA_WIDTH(DW), .NUM_READ(NR), .NUM_REGS(32)) dut (
        .CLK(CLK), .RST(RST), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
        .wen(wen), .rd(rd), .w_data(w_data), .w_single(w_single),
        .exc_valid(exc_valid), .exc_flags(exc_flags), .iss_valid(iss_valid), .iss_rd(iss_rd),
        .csr_wen(csr_wen), .csr_sel(csr_sel), .csr_wdata(csr_wdata), .instr_rm(instr_rm),
        .fflags(fflags), .frm(frm), .fcsr(fcsr), .rm_out(rm_out), .rm_illegal(rm_illegal)
    );

    // Clock and reset-phase bookkeeping
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Literal rs_data expectations: value queue plus the port each one belongs to.
    logic [DW-1:0] exp_q[$];
    int            exp_port_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: architectural state held as plain arrays.
    logic [DW-1:0] m_regs [32];
    bit            m_busy [32];
    logic [4:0]    m_fflags = '0;
    logic [2:0]    m_frm    = '0;

    function automatic logic [DW-1:0] write_value();
        return w_single ? {32'hFFFF_FFFF, w_data[31:0]} : w_data;
    endfunction

    function automatic logic [4:0] port_addr(input int p);
        return rs_addr[5*p +: 5];
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < 32; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
            m_fflags = '0;
            m_frm    = '0;
        end else begin
            if (wen) begin
                m_regs[rd] = write_value();
                m_busy[rd] = 1'b0;
            end
            if (iss_valid) m_busy[iss_rd] = 1'b1;
            if (csr_wen && csr_sel == 2'b01) m_fflags = csr_wdata[4:0];
            if (csr_wen && csr_sel == 2'b10) m_frm = csr_wdata[2:0];
            if (csr_wen && csr_sel == 2'b11) begin
                m_frm    = csr_wdata[7:5];
                m_fflags = csr_wdata[4:0];
            end
            if (exc_valid) m_fflags = m_fflags | exc_flags;
        end
    end

    // Compare process: every negedge outside reset cycles, plus any queued literals.
    always @(negedge CLK) begin
        if (chk_en && !RST) begin
            for (int p = 0; p < NR; p++) begin
                logic [4:0]    a;
                logic          hit;
                logic [2:0]    erm;
                a   = port_addr(p);
                hit = wen && (rd == a);
                check($sformatf("model_rs_data%0d", p), rs_data[DW*p +: DW],
                      hit ? write_value() : m_regs[a]);
                check($sformatf("model_rs_busy%0d", p), {63'd0, rs_busy[p]},
                      {63'd0, m_busy[a] && !hit});
                erm = (instr_rm == 3'd7) ? m_frm : instr_rm;
                if (p == 0) begin
                    check("model_fflags", {59'd0, fflags}, {59'd0, m_fflags});
                    check("model_frm", {61'd0, frm}, {61'd0, m_frm});
                    check("model_fcsr", {56'd0, fcsr}, {56'd0, m_frm, m_fflags});
                    check("model_rm_out", {61'd0, rm_out}, {61'd0, erm});
                    check("model_rm_illegal", {63'd0, rm_illegal}, {63'd0, erm >= 3'd5});
                end
            end
        end
        while (exp_q.size() > 0) begin
            int p;
            p = exp_port_q.pop_front();
            check($sformatf("literal_rs_data%0d", p), rs_data[DW*p +: DW], exp_q.pop_front());
        end
    end

    // Driver tasks
    task automatic clear_strobes();
        RST = 1'b0; wen = 1'b0; iss_valid = 1'b0; exc_valid = 1'b0; csr_wen = 1'b0;
        w_single = 1'b0; exc_flags = '0; csr_sel = '0; csr_wdata = '0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        clear_strobes();
    endtask

    task automatic expect_port(input int p, input logic [DW-1:0] v);
        exp_port_q.push_back(p);
        exp_q.push_back(v);
    endtask

    task automatic randomize_inputs();
        rd        = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
        for (int p = 0; p < NR; p++)
            rs_addr[5*p +: 5] = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
        wen       = 1'($urandom_range(0, 1));
        w_data    = {$urandom(), $urandom()};
        w_single  = 1'($urandom_range(0, 1));
        iss_valid = 1'($urandom_range(0, 1));
        iss_rd    = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
        exc_valid = ($urandom_range(0, 3) == 0);
        exc_flags = 5'($urandom_range(0, 31));
        csr_wen   = ($urandom_range(0, 7) == 0);
        csr_sel   = 2'($urandom_range(0, 3));
        csr_wdata = 8'($urandom_range(0, 255));
        instr_rm  = 3'($urandom_range(0, 7));
        RST       = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        clear_strobes();
        RST = 1'b1; rs_addr = '0; rd = '0; w_data = '0; iss_rd = '0; instr_rm = 3'b111;
        repeat (2) @(posedge CLK);
        #1;
        clear_strobes();
        chk_en = 1'b1;

        // Post-reset values with dynamic rounding selected
        @(negedge CLK);
        check("reset_rs_data", rs_data[DW-1:0], 64'd0);
        check("reset_rs_busy", {61'd0, rs_busy}, 64'd0);
        check("reset_fcsr", {56'd0, fcsr}, 64'd0);
        check("reset_rm_out", {61'd0, rm_out}, 64'd0);
        check("reset_rm_illegal", {63'd0, rm_illegal}, 64'd0);

        // Write f5 with same-cycle bypass, then the stored value
        tick();
        wen = 1'b1; rd = 5'd5; w_data = 64'h0000_0000_3F80_0000; rs_addr = {5'd0, 5'd0, 5'd5};
        expect_port(0, 64'h0000_0000_3F80_0000);
        tick();
        expect_port(0, 64'h0000_0000_3F80_0000);

        // NaN-boxed single write to f2 via port 1
        tick();
        wen = 1'b1; rd = 5'd2; w_single = 1'b1; w_data = 64'h1234_5678_4000_0000;
        rs_addr = {5'd0, 5'd2, 5'd0};
        expect_port(1, 64'hFFFF_FFFF_4000_0000);
        tick();
        expect_port(1, 64'hFFFF_FFFF_4000_0000);

        // Scoreboard on f7 read through port 2
        tick();
        iss_valid = 1'b1; iss_rd = 5'd7; rs_addr = {5'd7, 5'd0, 5'd0};
        @(negedge CLK);
        check("busy_same_cycle_issue", {63'd0, rs_busy[2]}, 64'd0);
        tick();
        @(negedge CLK);
        check("busy_after_issue", {63'd0, rs_busy[2]}, 64'd1);
        tick();
        wen = 1'b1; rd = 5'd7; w_data = 64'd9; iss_valid = 1'b1; iss_rd = 5'd7;
        @(negedge CLK);
        check("busy_wb_and_issue_now", {63'd0, rs_busy[2]}, 64'd0);
        tick();
        @(negedge CLK);
        check("busy_set_wins", {63'd0, rs_busy[2]}, 64'd1);
        tick();
        wen = 1'b1; rd = 5'd7;
        tick();
        @(negedge CLK);
        check("busy_cleared_by_wb", {63'd0, rs_busy[2]}, 64'd0);

        // Sticky flags, then CSR clear combined with a new NV
        tick();
        exc_valid = 1'b1; exc_flags = 5'b00001;
        tick();
        exc_valid = 1'b1; exc_flags = 5'b00100;
        tick();
        @(negedge CLK);
        check("fflags_accrue", {59'd0, fflags}, 64'h05);
        tick();
        csr_wen = 1'b1; csr_sel = 2'b01; csr_wdata = 8'h00; exc_valid = 1'b1; exc_flags = 5'b10000;
        tick();
        @(negedge CLK);
        check("fflags_csr_plus_exc", {59'd0, fflags}, 64'h10);

        // fcsr write and rounding-mode resolution
        tick();
        csr_wen = 1'b1; csr_sel = 2'b11; csr_wdata = 8'hE3;
        tick();
        instr_rm = 3'b111;
        @(negedge CLK);
        check("fcsr_frm", {61'd0, frm}, 64'd7);
        check("fcsr_fflags", {59'd0, fflags}, 64'h03);
        check("fcsr_value", {56'd0, fcsr}, 64'hE3);
        check("rm_dyn_out", {61'd0, rm_out}, 64'd7);
        check("rm_dyn_illegal", {63'd0, rm_illegal}, 64'd1);
        tick();
        instr_rm = 3'b001;
        @(negedge CLK);
        check("rm_static_out", {61'd0, rm_out}, 64'd1);
        check("rm_static_illegal", {63'd0, rm_illegal}, 64'd0);

        // Reset dominates simultaneous writeback, issue, CSR write and exception
        tick();
        RST = 1'b1; wen = 1'b1; rd = 5'd3; w_data = 64'hDEAD; iss_valid = 1'b1; iss_rd = 5'd3;
        csr_wen = 1'b1; csr_sel = 2'b11; csr_wdata = 8'hFF; exc_valid = 1'b1; exc_flags = 5'h1F;
        tick();
        instr_rm = 3'b111; rs_addr = {5'd3, 5'd2, 5'd5};
        @(negedge CLK);
        check("rst_rs_data", rs_data, '0);
        check("rst_rs_busy", {61'd0, rs_busy}, 64'd0);
        check("rst_fcsr", {56'd0, fcsr}, 64'd0);
        check("rst_rm_out", {61'd0, rm_out}, 64'd0);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            tick();
            randomize_inputs();
        end
        tick();
        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
